// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer and its HI/LO pair.
package muldiv_ctrl_pkg;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MUL  = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    localparam logic [1:0] MF_NONE = 2'b00;
    localparam logic [1:0] MF_HI   = 2'b01;
    localparam logic [1:0] MF_LO   = 2'b10;

    localparam logic MT_HI = 1'b0;
    localparam logic MT_LO = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Result held between the start edge and the commit edge.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } md_result_t;

endpackage

// File: rtl/muldiv_core.sv
// Combinational multiply/divide datapath; all cycle accounting lives in muldiv_ctrl.
module muldiv_core
    import muldiv_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_div,
    input  logic        is_unsigned,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [32:0] a_x;
    logic signed [32:0] b_x;
    logic signed [32:0] b_safe;
    logic signed [63:0] a_w;
    logic signed [63:0] b_w;
    logic signed [63:0] prod;
    logic        [31:0] quo;
    logic        [31:0] rem;

    // One extra sign bit lets a single signed datapath serve both signed and unsigned
    // forms, and keeps 0x80000000 / -1 from overflowing.
    always_comb begin
        a_x      = is_unsigned ? {1'b0, a} : {a[31], a};
        b_x      = is_unsigned ? {1'b0, b} : {b[31], b};
        a_w      = {{31{a_x[32]}}, a_x};
        b_w      = {{31{b_x[32]}}, b_x};
        prod     = a_w * b_w;
        div_zero = is_div & (b == 32'd0);
        b_safe   = (b == 32'd0) ? 33'sd1 : b_x;
        quo      = 32'(a_x / b_safe);
        rem      = 32'(a_x % b_safe);
        if (is_div) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the shared multiply/divide unit: fixed-latency busy window,
// HI/LO ownership, mt*/mf* access and the ID-stage stall.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  MulDiv_ex,
    input  logic        multu_ex,
    input  logic        MThilo_ex,
    input  logic        MTsel_ex,
    input  logic [1:0]  MFhilo_ex,
    input  logic [31:0] rs_val_ex,
    input  logic [31:0] rt_val_ex,
    input  logic        hilo_use_id,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data,
    output logic        busy,
    output logic        stall_id
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_result_t       pend_q, pend_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [31:0]      core_hi;
    logic [31:0]      core_lo;
    logic             core_dz;
    logic             start;

    muldiv_core u_core (
        .a           (rs_val_ex),
        .b           (rt_val_ex),
        .is_div      (MulDiv_ex == MD_DIV),
        .is_unsigned (multu_ex),
        .res_hi      (core_hi),
        .res_lo      (core_lo),
        .div_zero    (core_dz)
    );

    assign start = (state_q == ST_IDLE) & ((MulDiv_ex == MD_MUL) | (MulDiv_ex == MD_DIV));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                pend_d  = '{hi: core_hi, lo: core_lo, dz: core_dz};
                cnt_d   = (MulDiv_ex == MD_MUL) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                state_d = ST_BUSY;
            end else if (MThilo_ex) begin
                if (MTsel_ex == MT_HI) hi_d = rs_val_ex;
                else                   lo_d = rs_val_ex;
            end
        end else begin
            cnt_d = cnt_q - CNT_ONE;
            // Commit on the last busy edge; a zero divisor leaves HI/LO untouched.
            if (cnt_q == CNT_ONE) begin
                state_d = ST_IDLE;
                if (!pend_q.dz) begin
                    hi_d = pend_q.hi;
                    lo_d = pend_q.lo;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        case (MFhilo_ex)
            MF_HI:   mf_data = hi_q;
            MF_LO:   mf_data = lo_q;
            default: mf_data = 32'd0;
        endcase
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == ST_BUSY);
    assign stall_id = hilo_use_id & (busy | start);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus randomized ops against a plain-arithmetic model.
module tb_muldiv_ctrl;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  MulDiv_ex;
    logic        multu_ex;
    logic        MThilo_ex;
    logic        MTsel_ex;
    logic [1:0]  MFhilo_ex;
    logic [31:0] rs_val_ex;
    logic [31:0] rt_val_ex;
    logic        hilo_use_id;
    logic [31:0] hi, lo, mf_data;
    logic        busy, stall_id;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk         (clk),
        .reset       (reset),
        .MulDiv_ex   (MulDiv_ex),
        .multu_ex    (multu_ex),
        .MThilo_ex   (MThilo_ex),
        .MTsel_ex    (MTsel_ex),
        .MFhilo_ex   (MFhilo_ex),
        .rs_val_ex   (rs_val_ex),
        .rt_val_ex   (rt_val_ex),
        .hilo_use_id (hilo_use_id),
        .hi          (hi),
        .lo          (lo),
        .mf_data     (mf_data),
        .busy        (busy),
        .stall_id    (stall_id)
    );

    // Architectural effect of one mult/div on the model HI/LO.
    function automatic void ref_op(input logic [1:0] op, input logic u,
                                   input logic [31:0] a, input logic [31:0] b);
        longint      sp, sa, sb, q, r;
        logic [63:0] up;
        if (op == 2'b01) begin
            if (u) begin
                up   = 64'(a) * 64'(b);
                m_hi = up[63:32];
                m_lo = up[31:0];
            end else begin
                sp   = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
        end else if (op == 2'b10 && b != 32'd0) begin
            if (u) begin
                m_lo = a / b;
                m_hi = a % b;
            end else begin
                sa   = longint'($signed(a));
                sb   = longint'($signed(b));
                q    = sa / sb;
                r    = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
        end
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd1;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called on a negedge in IDLE; returns on the first IDLE negedge after commit.
    task automatic run_op(input logic [1:0] op, input logic u, input logic [31:0] a,
                          input logic [31:0] b, input logic use_id,
                          output int busy_n, output int stall_n, output logic stall0);
        busy_n      = 0;
        stall_n     = 0;
        MulDiv_ex   = op;
        multu_ex    = u;
        rs_val_ex   = a;
        rt_val_ex   = b;
        hilo_use_id = use_id;
        #1 stall0   = stall_id;
        @(negedge clk);
        MulDiv_ex = 2'b00;
        while (busy === 1'b1 && busy_n < 40) begin
            busy_n++;
            if (stall_id === 1'b1) stall_n++;
            // mt* while busy must be ignored
            MThilo_ex = 1'b1;
            MTsel_ex  = 1'($urandom);
            rs_val_ex = $urandom;
            @(negedge clk);
        end
        MThilo_ex   = 1'b0;
        hilo_use_id = 1'b0;
        ref_op(op, u, a, b);
    endtask

    task automatic do_mt(input logic sel, input logic [31:0] v);
        MThilo_ex = 1'b1;
        MTsel_ex  = sel;
        rs_val_ex = v;
        @(negedge clk);
        MThilo_ex = 1'b0;
        if (sel) m_lo = v;
        else     m_hi = v;
    endtask

    task automatic test_reset();
        int bn;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        MFhilo_ex = 2'b01;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (mf_data !== 32'd0) begin errors++; $display("FAIL reset_mf got=%h exp=0", mf_data); end
        MFhilo_ex = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        do_mt(1'b0, 32'hAAAA_0001);
        do_mt(1'b1, 32'hBBBB_0002);
        MulDiv_ex = 2'b10; multu_ex = 1'b0; rs_val_ex = 32'd100; rt_val_ex = 32'd7;
        @(negedge clk);
        MulDiv_ex = 2'b00;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy got=%0b exp=1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%0b exp=0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL async_hilo got=%h/%h exp=0/0", hi, lo); end
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        MFhilo_ex = 2'b01; hilo_use_id = 1'b1;
        #1;
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL post_reset_stall got=%0b exp=0", stall_id); end
        checks++; if (mf_data !== 32'd0) begin errors++; $display("FAIL post_reset_mfhi got=%h exp=0", mf_data); end
        MFhilo_ex = 2'b00; hilo_use_id = 1'b0;
        bn = 0;
        repeat (DIV_N + 2) begin @(negedge clk); if (busy === 1'b1) bn++; end
        checks++; if (bn != 0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL discarded_op busy_cycles=%0d hi=%h lo=%h exp=0/0/0", bn, hi, lo);
        end
    endtask

    task automatic test_mult();
        int bn, sn; logic s0;
        run_op(2'b01, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b0, bn, sn, s0);
        checks++; if (bn != MUL_N) begin errors++; $display("FAIL mult_busy got=%0d exp=%0d", bn, MUL_N); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            errors++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffffa", hi, lo);
        end
        run_op(2'b01, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, bn, sn, s0);
        checks++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL multu got=%h_%h exp=00000001_fffffffe", hi, lo);
        end
    endtask

    task automatic test_div();
        int bn, sn; logic s0;
        run_op(2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, bn, sn, s0);
        checks++; if (bn != DIV_N) begin errors++; $display("FAIL div_busy got=%0d exp=%0d", bn, DIV_N); end
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_neg got lo=%h hi=%h exp lo=fffffffd hi=ffffffff", lo, hi);
        end
        run_op(2'b10, 1'b1, 32'd7, 32'd2, 1'b0, bn, sn, s0);
        checks++; if (lo !== 32'd3 || hi !== 32'd1) begin
            errors++; $display("FAIL divu got lo=%h hi=%h exp lo=3 hi=1", lo, hi);
        end
        run_op(2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bn, sn, s0);
        checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
            errors++; $display("FAIL div_ovf got lo=%h hi=%h exp lo=80000000 hi=0", lo, hi);
        end
    endtask

    task automatic test_divzero();
        int bn, sn; logic s0;
        do_mt(1'b0, 32'h0000_1234);
        do_mt(1'b1, 32'h0000_5678);
        checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
            errors++; $display("FAIL mt got=%h/%h exp=1234/5678", hi, lo);
        end
        run_op(2'b10, 1'b0, 32'd99, 32'd0, 1'b0, bn, sn, s0);
        checks++; if (bn != DIV_N) begin errors++; $display("FAIL divzero_busy got=%0d exp=%0d", bn, DIV_N); end
        checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
            errors++; $display("FAIL divzero_hilo got=%h/%h exp=1234/5678", hi, lo);
        end
    endtask

    task automatic test_stall();
        int bn, sn; logic s0;
        run_op(2'b01, 1'b0, 32'd1000, 32'd77, 1'b1, bn, sn, s0);
        checks++; if (s0 !== 1'b1 || sn != MUL_N) begin
            errors++; $display("FAIL mflo_stall got start=%0b busy_stalls=%0d exp 1/%0d", s0, sn, MUL_N);
        end
        MFhilo_ex = 2'b10;
        #1;
        checks++; if (mf_data !== m_lo || stall_id !== 1'b0) begin
            errors++; $display("FAIL mflo_after got=%h stall=%0b exp=%h stall=0", mf_data, stall_id, m_lo);
        end
        MFhilo_ex = 2'b00;
        run_op(2'b01, 1'b1, 32'd5, 32'd6, 1'b0, bn, sn, s0);
        checks++; if (s0 !== 1'b0 || sn != 0) begin
            errors++; $display("FAIL add_nostall got start=%0b stalls=%0d exp 0/0", s0, sn);
        end
    endtask

    task automatic test_back_to_back();
        int bn, sn;
        logic [31:0] mh, ml;
        MulDiv_ex = 2'b01; multu_ex = 1'b0; rs_val_ex = 32'hFFFF_FF00; rt_val_ex = 32'd300;
        hilo_use_id = 1'b1;
        #1;
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL b2b_start_stall got=%0b exp=1", stall_id); end
        @(negedge clk);
        MulDiv_ex = 2'b10; rs_val_ex = 32'd1000; rt_val_ex = 32'hFFFF_FFFD;
        bn = 0; sn = 0;
        while (busy === 1'b1 && bn < 40) begin
            bn++;
            if (stall_id === 1'b1) sn++;
            @(negedge clk);
        end
        hilo_use_id = 1'b0;
        ref_op(2'b01, 1'b0, 32'hFFFF_FF00, 32'd300);
        mh = m_hi; ml = m_lo;
        checks++; if (bn != MUL_N || sn != MUL_N) begin
            errors++; $display("FAIL b2b_mult got busy=%0d stalls=%0d exp %0d/%0d", bn, sn, MUL_N, MUL_N);
        end
        checks++; if (hi !== mh || lo !== ml) begin
            errors++; $display("FAIL b2b_mult_hilo got=%h_%h exp=%h_%h", hi, lo, mh, ml);
        end
        @(negedge clk);
        MulDiv_ex = 2'b00;
        bn = 0;
        while (busy === 1'b1 && bn < 40) begin bn++; @(negedge clk); end
        ref_op(2'b10, 1'b0, 32'd1000, 32'hFFFF_FFFD);
        checks++; if (bn != DIV_N) begin errors++; $display("FAIL b2b_div_busy got=%0d exp=%0d", bn, DIV_N); end
        checks++; if (hi !== m_hi || lo !== m_lo) begin
            errors++; $display("FAIL b2b_div_hilo got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_random();
        int bn, sn, kind; logic s0;
        logic [31:0] a, b;
        logic u;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 3);
            a    = pick_operand();
            b    = pick_operand();
            u    = 1'($urandom);
            if (kind == 0) begin
                do_mt(u, a);
            end else if (kind == 3) begin
                MulDiv_ex = 2'b11; rs_val_ex = a; rt_val_ex = b;
                @(negedge clk);
                MulDiv_ex = 2'b00;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_reserved_busy i=%0d got=%0b exp=0", i, busy); end
            end else begin
                if (kind == 2 && $urandom_range(0, 4) == 0) b = 32'd0;
                run_op(2'(kind), u, a, b, 1'($urandom), bn, sn, s0);
                checks++; if (bn != ((kind == 1) ? MUL_N : DIV_N)) begin
                    errors++; $display("FAIL rnd_busy i=%0d got=%0d", i, bn);
                end
            end
            MFhilo_ex = 2'b01;
            #1;
            checks++; if (mf_data !== m_hi) begin
                errors++; $display("FAIL rnd_mfhi i=%0d kind=%0d a=%h b=%h u=%0b got=%h exp=%h", i, kind, a, b, u, mf_data, m_hi);
            end
            MFhilo_ex = 2'b10;
            #1;
            checks++; if (mf_data !== m_lo) begin
                errors++; $display("FAIL rnd_mflo i=%0d kind=%0d a=%h b=%h u=%0b got=%h exp=%h", i, kind, a, b, u, mf_data, m_lo);
            end
            MFhilo_ex = 2'b00;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; MulDiv_ex = 2'b00; multu_ex = 1'b0; MThilo_ex = 1'b0; MTsel_ex = 1'b0;
        MFhilo_ex = 2'b00; rs_val_ex = 32'd0; rt_val_ex = 32'd0; hilo_use_id = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_stall();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
